// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and defaults for the FIFO write arbiter: FSM state encoding,
// parameter defaults and a wrap-around increment used for the round-robin pointer.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int NUM_REQ_DEFAULT    = 4;
  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int MAX_BURST_DEFAULT  = 4;

  // Increment modulo n; correct for non-power-of-2 n.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side valid/ready bundle plus the FIFO write pins and grant status
// shared between the arbiter (slave) and its environment (master).
interface fifo_write_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);
  localparam int GW = $clog2(NUM_REQ);

  // Handshake: a word of producer i transfers in the cycle where
  // req_valid[i] & req_ready[i]; while valid and not ready the producer holds
  // req_data/req_last stable, and dropping valid ends that producer's grant.
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wen;
  logic [DATA_WIDTH-1:0]         fifo_in;
  logic                          fifo_is_full;
  logic                          grant_active;
  logic [GW-1:0]                 grant_id;

  modport master (
    output req_valid, req_last, req_data, fifo_is_full,
    input  req_ready, fifo_wen, fifo_in, grant_active, grant_id
  );

  modport slave (
    input  req_valid, req_last, req_data, fifo_is_full,
    output req_ready, fifo_wen, fifo_in, grant_active, grant_id
  );

endinterface

// File: rtl/fifo_write_arbiter_picker.sv
// Combinational round-robin search: first set request bit at or after i_ptr,
// wrapping past NUM_REQ-1 back to 0.
module rr_priority_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic                       o_found,
  output logic [$clog2(NUM_REQ)-1:0] o_idx
);
  localparam int GW = $clog2(NUM_REQ);

  // Walk from the farthest offset down so the nearest hit is written last.
  always_comb begin
    int j;
    j       = 0;
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(i_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (i_req[j]) begin
        o_found = 1'b1;
        o_idx   = GW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// granting one producer at a time for a burst of at most MAX_BURST words.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int MAX_BURST  = MAX_BURST_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_write_arbiter_if.slave  bus,
  output arb_state_t           o_state
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t    r_state;
  logic          r_grant_active;
  logic [GW-1:0] r_grant_id;
  logic [GW-1:0] r_rr_ptr;
  logic [CW-1:0] r_burst_cnt;

  logic          w_found;
  logic [GW-1:0] w_pick_idx;
  logic          w_busy;
  logic          w_g_valid;
  logic          w_g_last;
  logic          w_accept;
  logic          w_burst_end;
  logic          w_exit;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  assign w_busy      = (r_state == BUSY);
  assign w_g_valid   = bus.req_valid[r_grant_id];
  assign w_g_last    = bus.req_last[r_grant_id];
  assign w_accept    = w_busy & w_g_valid & ~bus.fifo_is_full;
  assign w_burst_end = (r_burst_cnt == CW'(MAX_BURST - 1));
  // A withdrawn grantee releases the port even while the FIFO is full.
  assign w_exit      = w_busy & (~w_g_valid | (w_accept & (w_g_last | w_burst_end)));

  always_comb begin
    bus.req_ready = '0;
    if (w_busy && !bus.fifo_is_full) bus.req_ready[r_grant_id] = 1'b1;
  end

  assign bus.fifo_wen     = w_accept;
  assign bus.fifo_in      = bus.req_data[int'(r_grant_id) * DATA_WIDTH +: DATA_WIDTH];
  assign bus.grant_active = r_grant_active;
  assign bus.grant_id     = r_grant_id;
  assign o_state          = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_grant_active <= 1'b0;
      r_grant_id     <= '0;
      r_rr_ptr       <= '0;
      r_burst_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state        <= BUSY;
            r_grant_active <= 1'b1;
            r_grant_id     <= w_pick_idx;
          end
        end
        BUSY: begin
          if (w_exit) begin
            r_state        <= IDLE;
            r_grant_active <= 1'b0;
            r_rr_ptr       <= GW'(wrap_inc(int'(r_grant_id), NUM_REQ));
            r_burst_cnt    <= '0;
          end else if (w_accept) begin
            r_burst_cnt <= r_burst_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: a 16-deep FIFO model, self-sequencing producers
// and a transaction-level arbitration model that predicts every cycle.
module tb_fifo_write_arbiter;
  import fifo_arb_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 16;
  localparam int GW    = $clog2(N);
  localparam int VW    = N + 1 + DW + 1 + GW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();
  arb_state_t dbg_state;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ---------------- bench state ----------------
  int errors = 0;
  int checks = 0;

  logic [5:0]    seq    [N];   // next sequence number each producer offers
  logic [5:0]    wr_seq [N];   // next sequence number expected in the FIFO
  logic [N-1:0]  pending;      // valid and not yet accepted: must hold last/data
  logic [DW-1:0] fifo_q [$];   // FIFO contents as written by the DUT
  logic [DW-1:0] exp_q  [$];   // words the reference model says were accepted
  bit            rd_en;
  int            dut_burst;

  // reference model: who owns the port, where the search resumes, words so far
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_cnt;

  logic [N-1:0]  obs_ready, exp_ready;
  logic          obs_wen, obs_active;
  logic [DW-1:0] obs_in;
  logic [GW-1:0] obs_gid;
  logic [VW-1:0] obs_v, exp_v;

  function automatic logic [DW-1:0] word(input int id, input logic [5:0] s);
    logic [1:0] idb;
    idb = 2'(id);
    return {idb, s};
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    logic [N-1:0] v, l;
    bit full, acc, r, hit;
    logic [DW-1:0] w, e;
    v = bus.req_valid; l = bus.req_last; full = bus.fifo_is_full; r = rst;
    @(negedge clk);
    obs_ready = bus.req_ready; obs_wen = bus.fifo_wen; obs_in = bus.fifo_in;
    obs_active = bus.grant_active; obs_gid = bus.grant_id;
    acc = m_busy && v[m_owner] && !full;
    exp_ready = '0;
    if (m_busy && !full) exp_ready[m_owner] = 1'b1;
    obs_v = {obs_ready, obs_wen, (obs_wen ? obs_in : DW'(0)), obs_active, obs_gid};
    exp_v = {exp_ready, acc, (acc ? word(m_owner, seq[m_owner]) : DW'(0)), m_busy, GW'(m_owner)};

    // scoreboard: FIFO read order against model-accepted order
    if (rd_en && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sb_read got=%h exp=<none>", w);
      end else begin
        e = exp_q.pop_front();
        if (w !== e) begin errors++; $display("FAIL sb_read got=%h exp=%h", w, e); end
      end
    end
    if (acc) exp_q.push_back(word(m_owner, seq[m_owner]));
    if (obs_active !== 1'b1) dut_burst = 0;
    if (obs_wen === 1'b1) begin
      fifo_q.push_back(obs_in);
      dut_burst++;
      checks++;
      if ($isunknown(obs_in)) begin
        errors++; $display("FAIL sb_order got=%h exp=known", obs_in);
      end else begin
        if (obs_in[5:0] !== wr_seq[obs_in[7:6]]) begin
          errors++;
          $display("FAIL sb_order id=%0d got=%0d exp=%0d", obs_in[7:6], obs_in[5:0], wr_seq[obs_in[7:6]]);
        end
        wr_seq[obs_in[7:6]] = obs_in[5:0] + 6'd1;
      end
    end

    for (int i = 0; i < N; i++) begin
      pending[i] = v[i] && (obs_ready[i] !== 1'b1);
      if (v[i] && obs_ready[i] === 1'b1) seq[i] = seq[i] + 6'd1;
    end

    if (r) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      hit = 0;
      for (int k = 0; k < N; k++) begin
        if (!hit && v[(m_ptr + k) % N]) begin
          hit = 1; m_busy = 1; m_owner = (m_ptr + k) % N;
        end
      end
    end else if (!v[m_owner] || (acc && (l[m_owner] || m_cnt + 1 == MB))) begin
      m_busy = 0; m_ptr = (m_owner + 1) % N; m_cnt = 0;
    end else if (acc) begin
      m_cnt++;
    end

    @(posedge clk); #1;
    bus.fifo_is_full = (fifo_q.size() >= DEPTH);
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = word(i, seq[i]);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.grant_active !== 1'b0) begin errors++; $display("FAIL rst_active got=%b exp=0", bus.grant_active); end
    checks++; if (bus.grant_id !== '0) begin errors++; $display("FAIL rst_gid got=%0d exp=0", bus.grant_id); end
    checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL rst_ready got=%b exp=0", bus.req_ready); end
    checks++; if (bus.fifo_wen !== 1'b0) begin errors++; $display("FAIL rst_wen got=%b exp=0", bus.fifo_wen); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state got=%b exp=IDLE", dbg_state); end
    @(posedge clk); #1;
    rst = 1'b0;
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic test_round_robin();
    bus.req_valid = '1; bus.req_last = '0; rd_en = 1;
    for (int c = 0; c < 25; c++) begin
      step();
      checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL rr_model c=%0d got=%h exp=%h", c, obs_v, exp_v); end
      checks++; if (obs_wen !== 1'((c % 5) != 0)) begin errors++; $display("FAIL rr_wen c=%0d got=%b exp=%b", c, obs_wen, (c % 5) != 0); end
      if (c % 5 != 0) begin
        checks++;
        if (obs_gid !== GW'(((c - 1) / 5) % N)) begin errors++; $display("FAIL rr_gid c=%0d got=%0d exp=%0d", c, obs_gid, ((c - 1) / 5) % N); end
      end
    end
    bus.req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL rr_drain c=%0d got=%h exp=%h", c, obs_v, exp_v); end
    end
  endtask

  task automatic test_single_last();
    bit vt [7] = '{1, 1, 1, 1, 1, 0, 0};
    bit lt [7] = '{0, 0, 1, 0, 0, 0, 0};
    bit at [7] = '{0, 1, 1, 0, 1, 1, 0};
    bit wt [7] = '{0, 1, 1, 0, 1, 0, 0};
    rd_en = 1;
    for (int c = 0; c < 7; c++) begin
      bus.req_valid = '0; bus.req_last = '0;
      bus.req_valid[2] = vt[c]; bus.req_last[2] = lt[c];
      step();
      checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL last_model c=%0d got=%h exp=%h", c, obs_v, exp_v); end
      checks++; if (obs_active !== at[c] || obs_wen !== wt[c]) begin
        errors++; $display("FAIL last_seq c=%0d got=%b%b exp=%b%b", c, obs_active, obs_wen, at[c], wt[c]);
      end
      if (at[c]) begin
        checks++; if (obs_gid !== GW'(2)) begin errors++; $display("FAIL last_gid c=%0d got=%0d exp=2", c, obs_gid); end
      end
    end
  endtask

  task automatic test_full_stall();
    int n;
    bus.req_valid = 4'b0001; bus.req_last = '0; rd_en = 0;
    n = 0;
    while (!bus.fifo_is_full && n < 80) begin
      step(); n++;
      checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL full_model n=%0d got=%h exp=%h", n, obs_v, exp_v); end
    end
    checks++; if (fifo_q.size() != DEPTH) begin errors++; $display("FAIL full_fill got=%0d exp=%0d", fifo_q.size(), DEPTH); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (obs_wen !== 1'b0) begin errors++; $display("FAIL stall_wen k=%0d got=%b exp=0", k, obs_wen); end
      if (k >= 1) begin
        checks++; if (obs_active !== 1'b1 || obs_gid !== '0) begin
          errors++; $display("FAIL stall_grant k=%0d got=%b/%0d exp=1/0", k, obs_active, obs_gid);
        end
      end
    end
    rd_en = 1; step(); rd_en = 0;
    checks++; if (obs_wen !== 1'b0) begin errors++; $display("FAIL stall_rd_wen got=%b exp=0", obs_wen); end
    step();
    checks++; if (obs_wen !== 1'b1) begin errors++; $display("FAIL resume_wen got=%b exp=1", obs_wen); end
    step();
    checks++; if (obs_wen !== 1'b0) begin errors++; $display("FAIL refull_wen got=%b exp=0", obs_wen); end
    bus.req_valid = '0; rd_en = 1;
    for (int k = 0; k < 24; k++) begin
      step();
      checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL full_drain k=%0d got=%h exp=%h", k, obs_v, exp_v); end
    end
  endtask

  task automatic test_withdraw();
    logic [N-1:0] vt [7] = '{4'b1010, 4'b1010, 4'b1000, 4'b1011, 4'b1011, 4'b0000, 4'b0000};
    bit at [7] = '{0, 1, 1, 0, 1, 1, 0};
    bit wt [7] = '{0, 1, 0, 0, 1, 0, 0};
    int gt [7] = '{-1, 1, 1, -1, 3, 3, -1};
    bus.req_last = '0; rd_en = 1;
    for (int c = 0; c < 7; c++) begin
      bus.req_valid = vt[c];
      step();
      checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL wd_model c=%0d got=%h exp=%h", c, obs_v, exp_v); end
      checks++; if (obs_active !== at[c] || obs_wen !== wt[c]) begin
        errors++; $display("FAIL wd_seq c=%0d got=%b%b exp=%b%b", c, obs_active, obs_wen, at[c], wt[c]);
      end
      if (gt[c] >= 0) begin
        checks++; if (obs_gid !== GW'(gt[c])) begin errors++; $display("FAIL wd_gid c=%0d got=%0d exp=%0d", c, obs_gid, gt[c]); end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [N-1:0] vt [11] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                              4'b1111, 4'b1111, 4'b0000, 4'b0000};
    bit at [11] = '{0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 0};
    bit wt [11] = '{0, 1, 0, 0, 1, 1, 1, 0, 1, 0, 0};
    int gt [11] = '{-1, 2, 2, -1, 2, 2, 2, 0, 0, 0, -1};
    bus.req_last = '0; rd_en = 1;
    for (int c = 0; c < 11; c++) begin
      bus.req_valid = vt[c];
      rst = (c == 6);
      step();
      rst = 1'b0;
      checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL rmb_model c=%0d got=%h exp=%h", c, obs_v, exp_v); end
      checks++; if (obs_active !== at[c] || obs_wen !== wt[c]) begin
        errors++; $display("FAIL rmb_seq c=%0d got=%b%b exp=%b%b", c, obs_active, obs_wen, at[c], wt[c]);
      end
      if (gt[c] >= 0) begin
        checks++; if (obs_gid !== GW'(gt[c])) begin errors++; $display("FAIL rmb_gid c=%0d got=%0d exp=%0d", c, obs_gid, gt[c]); end
      end
      if (c == 7) begin
        checks++; if (obs_ready !== '0) begin errors++; $display("FAIL rmb_ready got=%b exp=0", obs_ready); end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      if ((c / 500) % 2 == 0) rd_en = ($urandom_range(0, 3) != 0);
      else                    rd_en = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (pending[i]) begin
          if ($urandom_range(0, 15) == 0) bus.req_valid[i] = 1'b0;
        end else begin
          bus.req_valid[i] = ($urandom_range(0, 2) != 0);
          bus.req_last[i]  = ($urandom_range(0, 3) == 0);
        end
      end
      step();
      checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL rnd_model c=%0d got=%h exp=%h", c, obs_v, exp_v); end
      checks++; if ($countones(obs_ready) > 1 || $isunknown(obs_ready)) begin
        errors++; $display("FAIL rnd_onehot c=%0d got=%b exp=onehot0", c, obs_ready);
      end
      checks++; if (dut_burst > MB) begin errors++; $display("FAIL rnd_burst c=%0d got=%0d exp<=%0d", c, dut_burst, MB); end
    end
    bus.req_valid = '0; rd_en = 1;
    for (int k = 0; k < 40; k++) begin
      step();
      checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL rnd_drain k=%0d got=%h exp=%h", k, obs_v, exp_v); end
    end
    checks++; if (fifo_q.size() != 0) begin errors++; $display("FAIL end_fifo got=%0d exp=0", fifo_q.size()); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL end_expq got=%0d exp=0", exp_q.size()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    bus.req_valid = '0; bus.req_last = '0; bus.fifo_is_full = 1'b0;
    rd_en = 0; pending = '0; dut_burst = 0;
    for (int i = 0; i < N; i++) begin
      seq[i] = '0; wr_seq[i] = '0;
      bus.req_data[i*DW +: DW] = word(i, 6'd0);
    end
    test_reset();
    test_round_robin();
    test_single_last();
    test_full_stall();
    test_withdraw();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
